// File: rtl/l2tlb_multi.sv
// l2tlb_multi: parametrised, fully associative L2 TLB tagged by an SPTBR slot.
//
// Serves L1TLB lookups with a registered hit/miss response. Accepts fills from
// the page-walk path. On an SPTBR checkpoint it flushes every entry of one slot
// and then snoops the L1TLB with the flushed slot id.
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   req_valid/req_retry               lookup handshake (req_vpn, req_sid, req_rid)
//   rsp_valid/rsp_retry               response handshake (rsp_hit, rsp_ppn, rsp_rid)
//   fill_valid/fill_retry             fill handshake (fill_vpn, fill_ppn, fill_sid)
//   inv_valid/inv_retry               slot-invalidate handshake (inv_sid)
//   snoop_valid/snoop_retry           L1TLB snoop handshake (snoop_sid)
//   stat_hits, stat_misses            32-bit lookup counters
//
// Configuration
//   L2TLB_STATS_EN  defined: hit/miss counters are built.
//                   undefined: counters are absent and tied to zero.

module l2tlb_multi #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_SLOTS   = 4,
  parameter int VPN_W       = 27,
  parameter int PPN_W       = 19,
  parameter int RID_W       = 6,
  localparam int SID_W      = $clog2(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_retry,
  input  logic [VPN_W-1:0] req_vpn,
  input  logic [SID_W-1:0] req_sid,
  input  logic [RID_W-1:0] req_rid,
  output logic             rsp_valid,
  input  logic             rsp_retry,
  output logic             rsp_hit,
  output logic [PPN_W-1:0] rsp_ppn,
  output logic [RID_W-1:0] rsp_rid,
  input  logic             fill_valid,
  output logic             fill_retry,
  input  logic [VPN_W-1:0] fill_vpn,
  input  logic [PPN_W-1:0] fill_ppn,
  input  logic [SID_W-1:0] fill_sid,
  input  logic             inv_valid,
  output logic             inv_retry,
  input  logic [SID_W-1:0] inv_sid,
  output logic             snoop_valid,
  input  logic             snoop_retry,
  output logic [SID_W-1:0] snoop_sid,
  output logic [31:0]      stat_hits,
  output logic [31:0]      stat_misses
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_SNOOP} state_e;

  typedef struct packed {
    logic [SID_W-1:0] sid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
  } entry_t;

  state_e                 state_q, state_d;
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  entry_t                 ent_q [NUM_ENTRIES];
  entry_t                 ent_d [NUM_ENTRIES];
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [SID_W-1:0]       snoop_sid_q, snoop_sid_d;
  logic                   snoop_valid_q, snoop_valid_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_hit_q, rsp_hit_d;
  logic [PPN_W-1:0]       rsp_ppn_q, rsp_ppn_d;
  logic [RID_W-1:0]       rsp_rid_q, rsp_rid_d;

  logic             req_fire, fill_fire, inv_fire;
  logic             req_hit;
  logic [PPN_W-1:0] req_ppn;
  logic             fill_hit, free_found;
  logic [IDX_W-1:0] fill_hit_idx, free_idx;

  // Flow control. Reset forces every retry low; the invalidate wins over fill
  // and lookup in IDLE, and a stalled response blocks new lookups.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    inv_retry  = 1'b0;
    fill_retry = 1'b0;
    req_retry  = 1'b0;
    if (!reset) begin
      if (state_q == ST_IDLE) begin
        fill_retry = inv_valid;
        req_retry  = inv_valid | (rsp_valid_q & rsp_retry);
      end else begin
        inv_retry  = 1'b1;
        fill_retry = 1'b1;
        req_retry  = 1'b1;
      end
    end
  end

  assign req_fire  = req_valid  & ~req_retry  & (state_q == ST_IDLE) & ~reset;
  assign fill_fire = fill_valid & ~fill_retry & (state_q == ST_IDLE) & ~reset;
  assign inv_fire  = inv_valid  & ~inv_retry  & (state_q == ST_IDLE) & ~reset;

  // Lookup against the current (pre-fill) array. At most one entry matches,
  // so OR-ing the matching ppns yields the translation, or zero on a miss.
  always_comb begin
    req_hit = 1'b0;
    req_ppn = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && ent_q[i].sid == req_sid && ent_q[i].vpn == req_vpn) begin
        req_hit = 1'b1;
        req_ppn = req_ppn | ent_q[i].ppn;
      end
    end
  end

  // Fill placement: existing sid+vpn entry, else lowest-index invalid entry.
  always_comb begin
    fill_hit     = 1'b0;
    fill_hit_idx = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid_q[i] && ent_q[i].sid == fill_sid && ent_q[i].vpn == fill_vpn) begin
        fill_hit     = 1'b1;
        fill_hit_idx = IDX_W'(i);
      end
    end
    // Scanning downwards leaves the lowest free index as the final winner.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Array next state: slot flush, then fill write.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    rr_d    = rr_q;
    if (state_q == ST_FLUSH) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (ent_q[i].sid == snoop_sid_q) valid_d[i] = 1'b0;
      end
    end
    if (fill_fire) begin
      if (fill_hit) begin
        ent_d[fill_hit_idx].ppn = fill_ppn;
      end else if (free_found) begin
        valid_d[free_idx] = 1'b1;
        ent_d[free_idx]   = '{sid: fill_sid, vpn: fill_vpn, ppn: fill_ppn};
      end else begin
        ent_d[rr_q] = '{sid: fill_sid, vpn: fill_vpn, ppn: fill_ppn};
        rr_d        = rr_q + 1'b1;
      end
    end
  end

  // Response register: loads on an accepted lookup, clears once drained.
  // Payload is held after draining so it only changes on a new lookup.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_ppn_d   = rsp_ppn_q;
    rsp_rid_d   = rsp_rid_q;
    if (req_fire) begin
      rsp_valid_d = 1'b1;
      rsp_hit_d   = req_hit;
      rsp_ppn_d   = req_ppn;
      rsp_rid_d   = req_rid;
    end else if (rsp_valid_q && !rsp_retry) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Invalidate sequencer. snoop_sid_q doubles as the slot being flushed.
  always_comb begin
    state_d       = state_q;
    snoop_sid_d   = snoop_sid_q;
    snoop_valid_d = snoop_valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (inv_fire) begin
          state_d     = ST_FLUSH;
          snoop_sid_d = inv_sid;
        end
      end
      ST_FLUSH: begin
        state_d       = ST_SNOOP;
        snoop_valid_d = 1'b1;
      end
      ST_SNOOP: begin
        if (!snoop_retry) begin
          state_d       = ST_IDLE;
          snoop_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (reset) begin
      state_q       <= ST_IDLE;
      valid_q       <= '0;
      rr_q          <= '0;
      snoop_sid_q   <= '0;
      snoop_valid_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_ppn_q     <= '0;
      rsp_rid_q     <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      rr_q          <= rr_d;
      snoop_sid_q   <= snoop_sid_d;
      snoop_valid_q <= snoop_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_ppn_q     <= rsp_ppn_d;
      rsp_rid_q     <= rsp_rid_d;
    end
  end

  // NOTE: entry payload is not reset; the valid bits alone gate its use, so
  // the array stays plain storage without a reset network.
  always_ff @(posedge clk) begin
    ent_q <= ent_d;
  end

`ifdef L2TLB_STATS_EN
  logic [31:0] stat_hits_q, stat_hits_d;
  logic [31:0] stat_misses_q, stat_misses_d;

  always_comb begin
    stat_hits_d   = stat_hits_q;
    stat_misses_d = stat_misses_q;
    if (req_fire) begin
      if (req_hit) stat_hits_d   = stat_hits_q + 32'd1;
      else         stat_misses_d = stat_misses_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else begin
      stat_hits_q   <= stat_hits_d;
      stat_misses_q <= stat_misses_d;
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

  assign rsp_valid   = rsp_valid_q;
  assign rsp_hit     = rsp_hit_q;
  assign rsp_ppn     = rsp_ppn_q;
  assign rsp_rid     = rsp_rid_q;
  assign snoop_valid = snoop_valid_q;
  assign snoop_sid   = snoop_sid_q;

endmodule
